// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with full and ROB-age-selective flush.
// Define PIPE_SKID_EN for the two-entry build with a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W    = 72,
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  input  logic                 flush_all,
  input  logic                 flush_valid,
  input  logic [ROB_IDX_W-1:0] flush_rob_idx,
  input  logic [ROB_IDX_W-1:0] rob_head,
  output logic [1:0]           occupancy
);

  // Ages are taken relative to rob_head so the compare survives index wrap.
  function automatic logic killed(input logic [ROB_IDX_W-1:0] idx,
                                  input logic [ROB_IDX_W-1:0] head,
                                  input logic [ROB_IDX_W-1:0] fidx,
                                  input logic                 fvalid,
                                  input logic                 fall);
    logic [ROB_IDX_W-1:0] age_e;
    logic [ROB_IDX_W-1:0] age_f;
    age_e  = idx - head;
    age_f  = fidx - head;
    killed = fall || (fvalid && (age_e > age_f));
  endfunction

  logic                 m_valid_r;
  logic [DATA_W-1:0]    m_data_r;
  logic [ROB_IDX_W-1:0] m_idx_r;
  logic                 m_valid_mv_s;
  logic [DATA_W-1:0]    m_data_mv_s;
  logic [ROB_IDX_W-1:0] m_idx_mv_s;
  logic                 m_live_s;
  logic                 m_valid_d_s;
  logic [DATA_W-1:0]    m_data_d_s;
  logic [ROB_IDX_W-1:0] m_idx_d_s;
  logic                 accept_s;
  logic                 advance_s;

  assign advance_s = !m_valid_r || out_ready;
  assign accept_s  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
  logic                 s_valid_r;
  logic [DATA_W-1:0]    s_data_r;
  logic [ROB_IDX_W-1:0] s_idx_r;
  logic                 s_valid_mv_s;
  logic [DATA_W-1:0]    s_data_mv_s;
  logic [ROB_IDX_W-1:0] s_idx_mv_s;
  logic                 s_live_s;
  logic                 s_valid_d_s;
  logic [DATA_W-1:0]    s_data_d_s;
  logic [ROB_IDX_W-1:0] s_idx_d_s;

  assign in_ready  = !s_valid_r;
  assign occupancy = {m_valid_r & s_valid_r, m_valid_r ^ s_valid_r};

  // Movement: M refills from S first, else from the input; S catches a beat when M stalls.
  always_comb begin
    m_valid_mv_s = m_valid_r;
    m_data_mv_s  = m_data_r;
    m_idx_mv_s   = m_idx_r;
    s_valid_mv_s = s_valid_r;
    s_data_mv_s  = s_data_r;
    s_idx_mv_s   = s_idx_r;
    if (advance_s) begin
      if (s_valid_r) begin
        m_valid_mv_s = 1'b1;
        m_data_mv_s  = s_data_r;
        m_idx_mv_s   = s_idx_r;
        s_valid_mv_s = 1'b0;
      end else if (accept_s) begin
        m_valid_mv_s = 1'b1;
        m_data_mv_s  = in_data;
        m_idx_mv_s   = in_rob_idx;
      end else begin
        m_valid_mv_s = 1'b0;
      end
    end else if (accept_s) begin
      s_valid_mv_s = 1'b1;
      s_data_mv_s  = in_data;
      s_idx_mv_s   = in_rob_idx;
    end else begin
      s_valid_mv_s = s_valid_r;
    end
  end

  // Kill after movement; a surviving S is promoted into a killed M to keep order.
  always_comb begin
    m_live_s    = m_valid_mv_s && !killed(m_idx_mv_s, rob_head, flush_rob_idx, flush_valid, flush_all);
    s_live_s    = s_valid_mv_s && !killed(s_idx_mv_s, rob_head, flush_rob_idx, flush_valid, flush_all);
    m_valid_d_s = m_live_s;
    m_data_d_s  = m_data_mv_s;
    m_idx_d_s   = m_idx_mv_s;
    s_valid_d_s = s_live_s;
    s_data_d_s  = s_data_mv_s;
    s_idx_d_s   = s_idx_mv_s;
    if (!m_live_s && s_live_s) begin
      m_valid_d_s = 1'b1;
      m_data_d_s  = s_data_mv_s;
      m_idx_d_s   = s_idx_mv_s;
      s_valid_d_s = 1'b0;
    end else if (!m_live_s) begin
      m_data_d_s  = m_data_r;
      m_idx_d_s   = m_idx_r;
    end else begin
      m_valid_d_s = 1'b1;
    end
  end

  // Valid bits are the only reset state.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_d_s;
      s_valid_r <= s_valid_d_s;
    end
  end

  // Payload and ROB index registers carry no reset.
  always_ff @(posedge clk) begin
    m_data_r <= m_data_d_s;
    m_idx_r  <= m_idx_d_s;
    s_data_r <= s_data_d_s;
    s_idx_r  <= s_idx_d_s;
  end
`else
  assign in_ready  = advance_s;
  assign occupancy = {1'b0, m_valid_r};

  // Movement then kill for the single-entry build.
  always_comb begin
    m_valid_mv_s = m_valid_r;
    m_data_mv_s  = m_data_r;
    m_idx_mv_s   = m_idx_r;
    if (advance_s) begin
      if (accept_s) begin
        m_valid_mv_s = 1'b1;
        m_data_mv_s  = in_data;
        m_idx_mv_s   = in_rob_idx;
      end else begin
        m_valid_mv_s = 1'b0;
      end
    end else begin
      m_valid_mv_s = m_valid_r;
    end
    m_live_s    = m_valid_mv_s && !killed(m_idx_mv_s, rob_head, flush_rob_idx, flush_valid, flush_all);
    m_valid_d_s = m_live_s;
    if (m_live_s) begin
      m_data_d_s = m_data_mv_s;
      m_idx_d_s  = m_idx_mv_s;
    end else begin
      m_data_d_s = m_data_r;
      m_idx_d_s  = m_idx_r;
    end
  end

  // Valid bit is the only reset state.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_d_s;
    end
  end

  // Payload and ROB index registers carry no reset.
  always_ff @(posedge clk) begin
    m_data_r <= m_data_d_s;
    m_idx_r  <= m_idx_d_s;
  end
`endif

  assign out_valid   = m_valid_r;
  assign out_data    = m_data_r;
  assign out_rob_idx = m_idx_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based model; works
// with or without PIPE_SKID_EN.
module tb_pipe_stage_reg;
  localparam int DW = 72;
  localparam int IW = 4;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [IW-1:0] in_rob_idx, out_rob_idx, flush_rob_idx, rob_head;
  logic          flush_all, flush_valid;
  logic [1:0]    occupancy;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] xfer_log[$];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .ROB_IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rob_idx(in_rob_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_rob_idx(out_rob_idx),
    .flush_all(flush_all), .flush_valid(flush_valid),
    .flush_rob_idx(flush_rob_idx), .rob_head(rob_head), .occupancy(occupancy)
  );

  function automatic int age(input logic [IW-1:0] x, input logic [IW-1:0] h);
    return (int'(x) + 16 - int'(h)) % 16;
  endfunction

  // Stage capacity is 2 with the skid entry, else 1 with a pass-through ready.
  function automatic bit model_ready();
    if (SKID) return q.size() < 2;
    else return (q.size() == 0) || (out_ready == 1'b1);
  endfunction

  function automatic logic [3:0] exp_status();
    return {q.size() > 0, 2'(q.size()), model_ready()};
  endfunction

  function automatic logic [3:0] dut_status();
    return {out_valid, occupancy, in_ready};
  endfunction

  task automatic clear_inputs();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_rob_idx = '0;
    out_ready = 1'b0; flush_all = 1'b0; flush_valid = 1'b0;
    flush_rob_idx = '0; rob_head = '0;
  endtask

  // Advance one clock; the model applies consume, accept, then flush.
  task automatic tick();
    bit    acc;
    beat_t kept[$];
    acc = in_valid && model_ready();
    if (out_valid && out_ready) xfer_log.push_back(out_data);
    if (reset) begin
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) q.delete(0);
      if (acc) q.push_back({in_data, in_rob_idx});
      if (flush_all) begin
        q.delete();
      end else if (flush_valid) begin
        foreach (q[i])
          if (age(q[i].idx, rob_head) <= age(flush_rob_idx, rob_head)) kept.push_back(q[i]);
        q = kept;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (dut_status() !== 4'b0001) begin
      errors++; $display("FAIL reset_state: got %b want 0001", dut_status());
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dut_status() !== 4'b0001) begin
      errors++; $display("FAIL post_reset_ready: got %b want 0001", dut_status());
    end
  endtask

  task automatic test_streaming();
    clear_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i); in_rob_idx = IW'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(i) || dut_status() !== exp_status()) begin
        errors++;
        $display("FAIL stream beat %0d: got v=%b d=%0h st=%b want v=1 d=%0h st=%b",
                 i, out_valid, out_data, dut_status(), i, exp_status());
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (dut_status() !== exp_status()) begin
      errors++; $display("FAIL stream_drain: got %b want %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int peak = 0;
    bit acc;
    clear_inputs();
    xfer_log.delete();
    for (int step = 0; step < 18; step++) begin
      in_valid  = (sent < 10);
      in_data   = DW'(100 + sent);
      in_rob_idx = IW'(sent);
      out_ready = !(step >= 3 && step < 6);
      acc = in_valid && model_ready();
      tick();
      if (acc) sent++;
      if (int'(occupancy) > peak) peak = int'(occupancy);
      checks++;
      if (dut_status() !== exp_status()) begin
        errors++; $display("FAIL bp_status step %0d: got %b want %b", step, dut_status(), exp_status());
      end
      if (q.size() > 0) begin
        checks++;
        if ({out_data, out_rob_idx} !== q[0]) begin
          errors++; $display("FAIL bp_head step %0d: got %0h/%0d want %0h/%0d",
                             step, out_data, out_rob_idx, q[0].data, q[0].idx);
        end
      end
    end
    checks++;
    if (peak !== (SKID ? 2 : 1)) begin
      errors++; $display("FAIL bp_peak_occupancy: got %0d want %0d", peak, SKID ? 2 : 1);
    end
    checks++;
    if (xfer_log.size() !== 10) begin
      errors++; $display("FAIL bp_beat_count: got %0d want 10", xfer_log.size());
    end
    for (int k = 0; k < xfer_log.size() && k < 10; k++) begin
      checks++;
      if (xfer_log[k] !== DW'(100 + k)) begin
        errors++; $display("FAIL bp_order beat %0d: got %0h want %0h", k, xfer_log[k], 100 + k);
      end
    end
  endtask

  task automatic test_selective_flush();
    clear_inputs();
    rob_head = 4'd14;
    in_valid = 1'b1; in_data = DW'(72'hA15); in_rob_idx = 4'd15;
    tick();
    in_data = DW'(72'hB01); in_rob_idx = 4'd1;
    tick();
    in_valid = 1'b0; flush_valid = 1'b1; flush_rob_idx = 4'd15;
    tick();
    checks++;
    if (out_valid !== 1'b1 || occupancy !== 2'd1 || out_rob_idx !== 4'd15 || dut_status() !== exp_status()) begin
      errors++; $display("FAIL sel_flush_wrap: got v=%b occ=%0d idx=%0d want v=1 occ=1 idx=15",
                         out_valid, occupancy, out_rob_idx);
    end
    flush_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (dut_status() !== exp_status()) begin
      errors++; $display("FAIL sel_flush_drain: got %b want %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_flush_promotion();
    clear_inputs();
    in_valid = 1'b1; in_data = DW'(72'h2); in_rob_idx = 4'd2;
    tick();
    in_data = DW'(72'h3); in_rob_idx = 4'd3;
    tick();
    in_valid = 1'b0; flush_valid = 1'b1; flush_rob_idx = 4'd1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || dut_status() !== exp_status()) begin
      errors++; $display("FAIL flush_both: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
    end
    flush_valid = 1'b0;
  endtask

  task automatic test_flush_all();
    clear_inputs();
    xfer_log.delete();
    in_valid = 1'b1; in_data = DW'(72'hC0FFEE); in_rob_idx = 4'd5;
    tick();
    in_data = DW'(72'hDEAD); in_rob_idx = 4'd6; out_ready = 1'b1; flush_all = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== DW'(72'hC0FFEE) || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_all_pre: got v=%b d=%0h rdy=%b want v=1 d=c0ffee rdy=1",
                         out_valid, out_data, in_ready);
    end
    tick();
    checks++;
    if (xfer_log.size() !== 1 || dut_status() !== 4'b0001) begin
      errors++; $display("FAIL flush_all_post: got xfers=%0d st=%b want xfers=1 st=0001",
                         xfer_log.size(), dut_status());
    end
    flush_all = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (dut_status() !== exp_status() || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_all_drop: got %b want %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_ready_path();
    clear_inputs();
    in_valid = 1'b1; in_data = DW'(72'h11); in_rob_idx = 4'd1;
    tick();
    in_data = DW'(72'h12); in_rob_idx = 4'd2;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_full: got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== model_ready()) begin
      errors++; $display("FAIL ready_comb_path: got %b want %b", in_ready, model_ready());
    end
    flush_all = 1'b1;
    tick();
    flush_all = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    in_valid = 1'b1; in_data = DW'(72'h21); in_rob_idx = 4'd1;
    tick();
    in_data = DW'(72'h22); in_rob_idx = 4'd2;
    tick();
    checks++;
    if (occupancy !== (SKID ? 2'd2 : 2'd1)) begin
      errors++; $display("FAIL reset_mid_fill: got %0d want %0d", occupancy, SKID ? 2 : 1);
    end
    reset = 1'b1; out_ready = 1'b1; in_data = DW'(72'h23); in_rob_idx = 4'd3;
    tick();
    checks++;
    if (dut_status() !== 4'b0001 || dut_status() !== exp_status()) begin
      errors++; $display("FAIL reset_mid: got %b want 0001", dut_status());
    end
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_random();
    clear_inputs();
    flush_all = 1'b1;
    tick();
    for (int n = 0; n < 600; n++) begin
      out_ready  = ($urandom_range(0, 3) != 0);
      in_valid   = ($urandom_range(0, 2) != 0);
      in_data    = {$urandom, $urandom, $urandom};
      in_rob_idx = (q.size() > 0) ? q[$].idx + 4'd1 + 4'($urandom_range(0, 2)) : 4'($urandom);
      rob_head   = ((q.size() > 0) ? q[0].idx : in_rob_idx) - 4'($urandom_range(0, 4));
      flush_valid   = ($urandom_range(0, 9) == 0);
      flush_rob_idx = rob_head + 4'($urandom_range(0, 11));
      flush_all     = ($urandom_range(0, 39) == 0);
      reset         = ($urandom_range(0, 96) == 0);
      tick();
      checks++;
      if (dut_status() !== exp_status()) begin
        errors++; $display("FAIL rand_status cycle %0d: got %b want %b", n, dut_status(), exp_status());
      end
      if (q.size() > 0) begin
        checks++;
        if ({out_data, out_rob_idx} !== q[0]) begin
          errors++; $display("FAIL rand_head cycle %0d: got %0h/%0d want %0h/%0d",
                             n, out_data, out_rob_idx, q[0].data, q[0].idx);
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_selective_flush();
    test_flush_promotion();
    test_flush_all();
    test_ready_path();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
